// File: rtl/complex_pkg.sv
// Shared definitions for the complex accumulator: block state and the
// port-width rule used for the packed real/imaginary data buses.
package complex_pkg;

  typedef enum logic {
    FIRST = 1'b0,  // next accepted sample starts a new block
    ACCUM = 1'b1   // accepted samples are added to the running sum
  } state_e;

  // Bus width carrying one real and one imaginary component of width w.
  // Byte-aligned buses round the pair up to a multiple of 16 bits.
  function automatic int port_width(input int w, input int byte_aligned);
    return (byte_aligned != 0) ? ((2 * w + 15) / 16) * 16 : 2 * w;
  endfunction

endpackage

// File: rtl/cplx_saturate.sv
// Arithmetic right shift followed by saturation to a signed OUT_W range.
// One instance handles one component (real or imaginary).
module cplx_saturate #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  value_i,
  output logic signed [OUT_W-1:0] result_o,
  output logic                    sat_o
);

  // Working width is one bit wider than either side so the limits and the
  // shifted value compare correctly whichever of IN_W/OUT_W is larger.
  localparam int CW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

  logic signed [CW-1:0] value_ext;
  logic signed [CW-1:0] shifted;
  logic signed [CW-1:0] max_v;
  logic signed [CW-1:0] min_v;

  assign value_ext = {{(CW - IN_W){value_i[IN_W-1]}}, value_i};
  assign shifted   = value_ext >>> SHIFT;
  assign max_v     = {{(CW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  assign min_v     = {{(CW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Clamp the shifted value to the output range and flag any clamping.
  always_comb begin
    result_o = shifted[OUT_W-1:0];
    sat_o    = 1'b0;
    if (shifted > max_v) begin
      result_o = max_v[OUT_W-1:0];
      sat_o    = 1'b1;
    end else if (shifted < min_v) begin
      result_o = min_v[OUT_W-1:0];
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/complex_accumulator.sv
// Block accumulator for complex samples: sums acc_len accepted samples
// (minimum one), then emits the shifted, saturated sum on an AXI-Stream
// style output with one cycle of latency and full back-to-back throughput.
module complex_accumulator
  import complex_pkg::*;
#(
  parameter int OPERAND_WIDTH_IN  = 32,
  parameter int OPERAND_WIDTH_OUT = 32,
  parameter int ACC_LEN_WIDTH     = 8,
  parameter int OUT_SHIFT         = 0,
  parameter int BYTE_ALIGNED      = 1,
  localparam int EFF_IN  = port_width(OPERAND_WIDTH_IN, BYTE_ALIGNED),
  localparam int EFF_OUT = port_width(OPERAND_WIDTH_OUT, BYTE_ALIGNED)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ACC_LEN_WIDTH-1:0] acc_len,
  input  logic [EFF_IN-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [EFF_OUT-1:0]       m_axis_dout_tdata,
  output logic                     m_axis_dout_tvalid,
  input  logic                     m_axis_dout_tready,
  output logic                     sat_flag
);

  // Accumulator is wide enough for 2^ACC_LEN_WIDTH-1 full-scale samples.
  localparam int AW       = OPERAND_WIDTH_IN + ACC_LEN_WIDTH;
  localparam int HALF_IN  = EFF_IN / 2;
  localparam int HALF_OUT = EFF_OUT / 2;
  localparam int OW       = OPERAND_WIDTH_OUT;

  state_e                    state_q, state_d;
  logic [ACC_LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ACC_LEN_WIDTH-1:0]  len_q, len_d;
  logic signed [AW-1:0]      acc_re_q, acc_re_d;
  logic signed [AW-1:0]      acc_im_q, acc_im_d;
  logic                      tvalid_q, tvalid_d;
  logic [EFF_OUT-1:0]        tdata_q, tdata_d;
  logic                      sat_q, sat_d;

  logic                      accept;
  logic                      last;
  logic [ACC_LEN_WIDTH-1:0]  n_eff;
  logic [ACC_LEN_WIDTH-1:0]  cnt_next;
  logic signed [AW-1:0]      in_re, in_im;
  logic signed [AW-1:0]      sum_re, sum_im;
  logic signed [OW-1:0]      res_re, res_im;
  logic                      sat_re, sat_im;
  logic [HALF_OUT-1:0]       out_re_ext, out_im_ext;

  // Input ready whenever the output register is free or being drained;
  // held low during reset so nothing is accepted then.
  assign s_axis_tready = aresetn && (!tvalid_q || m_axis_dout_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign in_re = {{ACC_LEN_WIDTH{s_axis_tdata[OPERAND_WIDTH_IN-1]}},
                  s_axis_tdata[OPERAND_WIDTH_IN-1:0]};
  assign in_im = {{ACC_LEN_WIDTH{s_axis_tdata[HALF_IN+OPERAND_WIDTH_IN-1]}},
                  s_axis_tdata[HALF_IN+OPERAND_WIDTH_IN-1:HALF_IN]};

  // Running sum including the sample offered this cycle; the block length
  // is taken from acc_len only when a block starts.
  always_comb begin
    if (state_q == FIRST) begin
      sum_re   = in_re;
      sum_im   = in_im;
      n_eff    = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
      cnt_next = ACC_LEN_WIDTH'(1);
    end else begin
      sum_re   = acc_re_q + in_re;
      sum_im   = acc_im_q + in_im;
      n_eff    = len_q;
      cnt_next = cnt_q + ACC_LEN_WIDTH'(1);
    end
    last = (cnt_next == n_eff);
  end

  cplx_saturate #(
    .IN_W  (AW),
    .OUT_W (OW),
    .SHIFT (OUT_SHIFT)
  ) u_sat_re (
    .value_i  (sum_re),
    .result_o (res_re),
    .sat_o    (sat_re)
  );

  cplx_saturate #(
    .IN_W  (AW),
    .OUT_W (OW),
    .SHIFT (OUT_SHIFT)
  ) u_sat_im (
    .value_i  (sum_im),
    .result_o (res_im),
    .sat_o    (sat_im)
  );

  if (HALF_OUT > OW) begin : g_ext
    assign out_re_ext = {{(HALF_OUT - OW){res_re[OW-1]}}, res_re};
    assign out_im_ext = {{(HALF_OUT - OW){res_im[OW-1]}}, res_im};
  end else begin : g_no_ext
    assign out_re_ext = res_re;
    assign out_im_ext = res_im;
  end

  // Next-state logic: advance the block on each accepted sample, register
  // the result on the last one, and drop tvalid once it is taken.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    tvalid_d = tvalid_q && !m_axis_dout_tready;
    tdata_d  = tdata_q;
    sat_d    = sat_q;
    if (accept) begin
      if (last) begin
        state_d  = FIRST;
        cnt_d    = '0;
        tvalid_d = 1'b1;
        tdata_d  = {out_im_ext, out_re_ext};
        sat_d    = sat_re || sat_im;
      end else begin
        state_d  = ACCUM;
        cnt_d    = cnt_next;
        acc_re_d = sum_re;
        acc_im_d = sum_im;
        if (state_q == FIRST) begin
          len_d = n_eff;
        end
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every register updates together at the edge.
    if (!aresetn) begin
      state_q  <= FIRST;
      cnt_q    <= '0;
      len_q    <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      sat_q    <= sat_d;
    end
  end

  assign m_axis_dout_tvalid = tvalid_q;
  assign m_axis_dout_tdata  = tdata_q;
  assign sat_flag           = sat_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Self-checking bench: two 16-bit instances (OUT_SHIFT 0 and 2) share one
// stimulus stream; a block-level model predicts outputs every cycle, and
// directed scenarios pin the model with hand-computed results.
module tb_complex_accumulator;
  import complex_pkg::*;

  localparam int W    = 16;
  localparam int OW   = 16;
  localparam int LW   = 8;
  localparam int EFF  = port_width(W, 1);
  localparam int SH_B = 2;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [LW-1:0]   acc_len;
  logic [EFF-1:0]  s_tdata;
  logic            s_tvalid;
  logic            m_tready;
  logic            tready_a, tready_b;
  logic [EFF-1:0]  tdata_a, tdata_b;
  logic            tvalid_a, tvalid_b;
  logic            sat_a, sat_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 aclk = ~aclk;

  complex_accumulator #(
    .OPERAND_WIDTH_IN (W), .OPERAND_WIDTH_OUT (OW), .ACC_LEN_WIDTH (LW),
    .OUT_SHIFT (0), .BYTE_ALIGNED (1)
  ) dut_a (
    .aclk (aclk), .aresetn (aresetn), .acc_len (acc_len),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tready (tready_a),
    .m_axis_dout_tdata (tdata_a), .m_axis_dout_tvalid (tvalid_a),
    .m_axis_dout_tready (m_tready), .sat_flag (sat_a)
  );

  complex_accumulator #(
    .OPERAND_WIDTH_IN (W), .OPERAND_WIDTH_OUT (OW), .ACC_LEN_WIDTH (LW),
    .OUT_SHIFT (SH_B), .BYTE_ALIGNED (1)
  ) dut_b (
    .aclk (aclk), .aresetn (aresetn), .acc_len (acc_len),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tready (tready_b),
    .m_axis_dout_tdata (tdata_b), .m_axis_dout_tvalid (tvalid_b),
    .m_axis_dout_tready (m_tready), .sat_flag (sat_b)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint sat_model(input longint v, input int sh, output bit s);
    longint t, hi, lo;
    t  = v >>> sh;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -hi - 1;
    s  = 1'b0;
    if (t > hi) begin t = hi; s = 1'b1; end
    else if (t < lo) begin t = lo; s = 1'b1; end
    return t;
  endfunction

  bit     started   = 1'b0;
  bit     exp_valid = 1'b0;
  longint exp_re_a, exp_im_a, exp_re_b, exp_im_b;
  bit     exp_sat_a, exp_sat_b;
  int     blk_n     = 1;
  longint blk_re[$];
  longint blk_im[$];
  longint obs_re[$];
  longint obs_im[$];
  bit     obs_sat[$];

  // Checks outputs against the model at the falling edge, then advances the
  // model with the inputs that the next rising edge will sample.
  always @(negedge aclk) begin
    bit     exp_tready, acc, sr, si;
    longint sum_re, sum_im;
    exp_tready = aresetn && (!exp_valid || m_tready);
    if (started) begin
      check("tready_a", tready_a, exp_tready);
      check("tready_b", tready_b, exp_tready);
      check("tvalid_a", tvalid_a, exp_valid);
      check("tvalid_b", tvalid_b, exp_valid);
      if (exp_valid) begin
        check("re_a",  $signed(tdata_a[15:0]),  exp_re_a);
        check("im_a",  $signed(tdata_a[31:16]), exp_im_a);
        check("sat_a", sat_a, exp_sat_a);
        check("re_b",  $signed(tdata_b[15:0]),  exp_re_b);
        check("im_b",  $signed(tdata_b[31:16]), exp_im_b);
        check("sat_b", sat_b, exp_sat_b);
      end
      if (tvalid_a === 1'b1 && m_tready) begin
        obs_re.push_back(longint'($signed(tdata_a[15:0])));
        obs_im.push_back(longint'($signed(tdata_a[31:16])));
        obs_sat.push_back(sat_a);
      end
    end
    if (!aresetn) begin
      started   = 1'b1;
      exp_valid = 1'b0;
      blk_re.delete();
      blk_im.delete();
    end else if (started) begin
      acc = s_tvalid && exp_tready;
      if (exp_valid && m_tready) exp_valid = 1'b0;
      if (acc) begin
        if (blk_re.size() == 0) blk_n = (acc_len == 0) ? 1 : int'(acc_len);
        blk_re.push_back(longint'($signed(s_tdata[15:0])));
        blk_im.push_back(longint'($signed(s_tdata[31:16])));
        if (blk_re.size() == blk_n) begin
          sum_re = 0;
          sum_im = 0;
          foreach (blk_re[i]) begin
            sum_re += blk_re[i];
            sum_im += blk_im[i];
          end
          exp_re_a  = sat_model(sum_re, 0, sr);
          exp_im_a  = sat_model(sum_im, 0, si);
          exp_sat_a = sr || si;
          exp_re_b  = sat_model(sum_re, SH_B, sr);
          exp_im_b  = sat_model(sum_im, SH_B, si);
          exp_sat_b = sr || si;
          exp_valid = 1'b1;
          blk_re.delete();
          blk_im.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input longint re, input longint im);
    int k = 0;
    s_tdata  = {16'(im), 16'(re)};
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!tready_a && k < 100) begin
      @(negedge aclk);
      k++;
    end
    check("send_accept", tready_a, 1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs_re.size() < n && k < 200) begin
      @(negedge aclk);
      k++;
    end
    check("result_count", obs_re.size(), n);
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_obs();
    obs_re.delete();
    obs_im.delete();
    obs_sat.delete();
  endtask

  initial begin
    int lens[6];
    lens = '{0, 1, 2, 3, 5, 17};
    aresetn  = 1'b0;
    acc_len  = 8'd4;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", tvalid_a, 0);
    check("rst_tdata",  tdata_a, 0);
    check("rst_sat",    sat_a, 0);
    check("rst_tready", tready_a, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Four (1+2j) with acc_len=4 -> (4+8j), no saturation.
    clear_obs();
    repeat (4) send(1, 2);
    wait_obs(1);
    check("sum4_re", obs_re[0], 4);
    check("sum4_im", obs_im[0], 8);
    check("sum4_sat", obs_sat[0], 0);

    // acc_len=0 behaves as 1: every sample passes through.
    clear_obs();
    acc_len = 8'd0;
    send(3, -1);
    send(-5, 7);
    wait_obs(2);
    check("n1_re0", obs_re[0], 3);
    check("n1_im0", obs_im[0], -1);
    check("n1_re1", obs_re[1], -5);
    check("n1_im1", obs_im[1], 7);

    // Output stall: result held, input blocked, nothing lost.
    clear_obs();
    acc_len  = 8'd1;
    m_tready = 1'b0;
    send(10, 20);
    s_tdata  = {16'(21), 16'(11)};
    s_tvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      check("stall_tready", tready_a, 0);
      check("stall_tdata",  tdata_a, 64'h0014_000A);
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    send(11, 21);
    wait_obs(2);
    check("stall_re0", obs_re[0], 10);
    check("stall_im0", obs_im[0], 20);
    check("stall_re1", obs_re[1], 11);
    check("stall_im1", obs_im[1], 21);

    // Saturation: 2 x (32767-32768j) clamps to (32767-32768j).
    clear_obs();
    acc_len = 8'd2;
    repeat (2) send(32767, -32768);
    wait_obs(1);
    check("sat_re",  obs_re[0], 32767);
    check("sat_im",  obs_im[0], -32768);
    check("sat_flg", obs_sat[0], 1);

    // Reset mid-block discards the partial sum.
    acc_len = 8'd4;
    repeat (2) send(1, 1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clear_obs();
    repeat (4) send(1, 1);
    wait_obs(1);
    repeat (5) @(posedge aclk);
    #1;
    check("rst_blk_count", obs_re.size(), 1);
    check("rst_blk_re", obs_re[0], 4);
    check("rst_blk_im", obs_im[0], 4);

    // acc_len change mid-block takes effect on the next block only.
    clear_obs();
    acc_len = 8'd4;
    send(1, 0);
    acc_len = 8'd2;
    send(2, 0);
    send(3, 0);
    send(4, 0);
    send(5, 0);
    send(6, 0);
    wait_obs(2);
    check("len_chg_blk0", obs_re[0], 10);
    check("len_chg_blk1", obs_re[1], 11);

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge aclk);
      #1;
      s_tvalid = ($urandom_range(99) < 70);
      if ($urandom_range(3) == 0) begin
        s_tdata = {16'(int'($urandom_range(15)) - 8), 16'(int'($urandom_range(15)) - 8)};
      end else begin
        s_tdata = EFF'($urandom);
      end
      m_tready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) acc_len = LW'(lens[$urandom_range(5)]);
      aresetn = ($urandom_range(999) >= 3);
    end

    @(posedge aclk);
    #1;
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (10) @(posedge aclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
